vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_arbiter_fifo.sv | 47 ++++
 rtl/vram_arbiter.sv | 113 +++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: default RAM geometry, the read-tag enum
// and the packed draw-command layout.
package vram_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_DRAW = 2'd2
  } rtag_e;

  typedef struct packed {
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/vram_arbiter_fifo.sv
// vram_cmd_fifo: 2-entry in-order draw-command queue with a registered
// occupancy count; storage is not reset, only the pointers and count are.
module vram_cmd_fifo
  import vram_pkg::*;
#(
  parameter int W = $bits(cmd_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout reads always win, draw commands
// queue in a 2-deep FIFO. Define VRAM_ARB_STALL_CNT_EN to add the stall_cnt port.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              drw_valid,
  output logic              drw_ready,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_rvalid,
  output logic [DATA_W-1:0] drw_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;

  logic              r_live;
  rtag_e             r_tag_p1;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_disp_rd;
  logic [CMD_W-1:0]  w_head;
  logic              w_head_we;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;

  vram_cmd_fifo #(.W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({drw_we, drw_addr, drw_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // r_live keeps every output quiet until the first edge after reset release.
  assign drw_ready = r_live & ~w_full;
  assign w_push    = drw_valid & drw_ready;
  assign w_disp_rd = r_live & disp_req;
  assign w_pop     = r_live & ~disp_req & ~w_empty;
  assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_disp_rd) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (w_pop) begin
      ram_en   = 1'b1;
      ram_we   = w_head_we;
      ram_addr = w_head_addr;
      if (w_head_we) ram_wdata = w_head_wdata;
    end
  end

  // Issue stage -> return stage: tag tracks who owns next cycle's ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_tag_p1 <= TAG_NONE;
    end else begin
      r_live <= 1'b1;
      if (w_disp_rd)                r_tag_p1 <= TAG_DISP;
      else if (w_pop && !w_head_we) r_tag_p1 <= TAG_DRAW;
      else                          r_tag_p1 <= TAG_NONE;
    end
  end

  assign disp_rvalid = (r_tag_p1 == TAG_DISP);
  assign drw_rvalid  = (r_tag_p1 == TAG_DRAW);
  assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
  assign drw_rdata   = drw_rvalid  ? ram_rdata : '0;

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (disp_req && !w_empty && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a queue-based
// transaction model with a shadow memory; honours VRAM_ARB_STALL_CNT_EN.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        drw_valid;
  logic        drw_ready;
  logic        drw_we;
  logic [16:0] drw_addr;
  logic [7:0]  drw_wdata;
  logic        drw_rvalid;
  logic [7:0]  drw_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  vram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .drw_valid   (drw_valid),
    .drw_ready   (drw_ready),
    .drw_we      (drw_we),
    .drw_addr    (drw_addr),
    .drw_wdata   (drw_wdata),
    .drw_rvalid  (drw_rvalid),
    .drw_rdata   (drw_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment RAM: single port, read data valid the cycle after the read.
  logic [7:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Reference model state.
  typedef struct {
    bit          we;
    logic [16:0] addr;
    logic [7:0]  wdata;
  } cmd_s;

  logic [7:0]  shadow [0:131071];
  cmd_s        mq[$];
  bit          live;
  bit          exp_rv_disp;
  bit          exp_rv_drw;
  logic [7:0]  exp_data;
  logic [31:0] exp_stall;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    live        = 1'b0;
    exp_rv_disp = 1'b0;
    exp_rv_drw  = 1'b0;
    exp_data    = '0;
    exp_stall   = '0;
  endtask

  task automatic step(input bit dreq, input logic [16:0] daddr, input bit dv,
                      input bit we, input logic [16:0] addr, input logic [7:0] wd,
                      output bit acc);
    bit          rdy, e_en, e_we, pop;
    logic [16:0] e_addr;
    logic [7:0]  e_wd;
    cmd_s        c;
    @(negedge clk);
    disp_req  = dreq;
    disp_addr = daddr;
    drw_valid = dv;
    drw_we    = we;
    drw_addr  = addr;
    drw_wdata = wd;
    #1;
    check_eq("disp_rvalid", disp_rvalid, exp_rv_disp);
    check_eq("drw_rvalid", drw_rvalid, exp_rv_drw);
    if (exp_rv_disp) check_eq("disp_rdata", disp_rdata, exp_data);
    if (exp_rv_drw)  check_eq("drw_rdata", drw_rdata, exp_data);
    rdy = live && (mq.size() < 2);
    check_eq("drw_ready", drw_ready, rdy);
`ifdef VRAM_ARB_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, exp_stall);
    if (dreq && mq.size() > 0 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; pop = 0;
    if (live && dreq) begin
      e_en = 1; e_addr = daddr;
    end else if (live && mq.size() > 0) begin
      c = mq[0]; pop = 1;
      e_en = 1; e_we = c.we; e_addr = c.addr;
      if (c.we) e_wd = c.wdata;
    end
    check_eq("ram_en", ram_en, e_en);
    check_eq("ram_we", ram_we, e_we);
    check_eq("ram_addr", ram_addr, e_addr);
    if (e_we || !e_en) check_eq("ram_wdata", ram_wdata, e_wd);
    exp_rv_disp = 0;
    exp_rv_drw  = 0;
    if (live && dreq) begin
      exp_rv_disp = 1; exp_data = shadow[daddr];
    end else if (pop) begin
      if (c.we) shadow[c.addr] = c.wdata;
      else begin exp_rv_drw = 1; exp_data = shadow[c.addr]; end
      void'(mq.pop_front());
    end
    acc = dv && rdy;
    if (acc) mq.push_back('{we: we, addr: addr, wdata: wd});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, a);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n     = 1'b0;
      disp_req  = 1'b1;
      disp_addr = 17'h10;
      drw_valid = 1'b1;
      drw_we    = 1'b0;
      #1;
      model_clear();
      check_eq("rst_disp_rvalid", disp_rvalid, 0);
      check_eq("rst_drw_rvalid", drw_rvalid, 0);
      check_eq("rst_drw_ready", drw_ready, 0);
      check_eq("rst_ram_en", ram_en, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_disp_rdata", disp_rdata, 0);
`ifdef VRAM_ARB_STALL_CNT_EN
      check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
    end
    @(negedge clk);
    rst_n     = 1'b1;
    disp_req  = 1'b0;
    disp_addr = '0;
    drw_valid = 1'b0;
    #1;
    check_eq("rel_drw_ready", drw_ready, 0);
    check_eq("rel_ram_en", ram_en, 0);
    live = 1'b1;
  endtask

  function automatic logic [16:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 17'h12345;
      1:       return 17'h1FFFF;
      default: return 17'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    bit a;
    int k;
    rst_n = 1'b1; disp_req = 0; disp_addr = '0; drw_valid = 0;
    drw_we = 0; drw_addr = '0; drw_wdata = '0;
    for (int i = 0; i < 131072; i++) begin
      ram[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    ram[17'h10]    = 8'hA5;
    shadow[17'h10] = 8'hA5;
    model_clear();
    #1 rst_n = 1'b0;
    do_reset(2);

    // Display read of a known location.
    step(1, 17'h10, 0, 0, '0, '0, a);
    @(negedge clk); #1;
    check_eq("disp_a5_valid", disp_rvalid, 1);
    check_eq("disp_a5_data", disp_rdata, 8'hA5);
    check_eq("disp_a5_drw_rvalid", drw_rvalid, 0);
    step(0, '0, 0, 0, '0, '0, a);
    idle(1);

    // Draw write then read back through the queue.
    step(0, '0, 1, 1, 17'h12345, 8'h3C, a);
    step(0, '0, 1, 0, 17'h12345, 8'h00, a);
    idle(3);

    // Contention: display holds the port while three draw commands are offered.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 17'(i), k < 3, 1'(k), 17'h100 + 17'(k), 8'(8'h50 + k), a);
      if (a) k++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, k < 3, 1'(k), 17'h100 + 17'(k), 8'(8'h50 + k), a);
      if (a) k++;
    end
    idle(3);

    // Back-to-back draw traffic with the display idle.
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, i[0], 17'h200 + 17'(i >> 1), 8'(i * 17), a);
      check_eq("b2b_accept", a, 1);
    end
    idle(3);

    // Reset with a full queue and a display read in flight.
    for (int i = 0; i < 3; i++) step(1, 17'h10, 1, 0, 17'h12345, '0, a);
    do_reset(2);
    idle(3);

    // Randomized traffic with one reset part-way through.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      step($urandom_range(0, 9) < 4, rnd_addr(), $urandom_range(0, 9) < 6,
           1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), a);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
